dram_ctrl: RTL and testbench
============================

Name: dram_ctrl

Overview:
- Single-port controller sequencing the off-chip DRAM pins (CSn, WEn[3:0], RASn, CASn, A[10:0], D, Q, VALID) for 32-bit word reads and byte-masked writes.
- Accepts one request at a time from the system-side wrapper (AXI slave bridge) and issues ACT / READ / WRITE / PRE commands with parameterised timing.
- Sits between the DRAM slave wrapper inside top and the top-level DRAM ports.

Parameters:
- T_RCD, 5, cycles from ACT to the first column command.
- T_RP, 5, cycles from PRE to the next ACT.
- T_CL, 5, maximum cycles from READ to VALID (timeout guard).
- T_WR, 5, cycles after WRITE before PRE or the next command.

Ports:
- clk  in  1  clock (all logic on the rising edge).
- rst  in  1  reset; asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle (valid & ready).
- req_we  in  1  1 = write, 0 = read.
- req_strb  in  4  byte enables for a write; ignored for a read.
- req_addr  in  32  byte address; word address = [22:2], row = [22:12], column = [11:2].
- req_wdata  in  32  write data.
- rsp_valid  out  1  one-cycle pulse marking the end of a read or write.
- rsp_rdata  out  32  read data, valid while rsp_valid = 1.
- rsp_err  out  1  read timeout flag, valid while rsp_valid = 1.
- DRAM_CSn  out  1  chip select.
- DRAM_RASn  out  1  row strobe.
- DRAM_CASn  out  1  column strobe.
- DRAM_WEn  out  4  byte write enables, active-low.
- DRAM_A  out  11  row or column address.
- DRAM_D  out  32  write data.
- DRAM_Q  in  32  read data.
- DRAM_valid  in  1  read data valid.

Behaviour:
- Command encoding {CSn,RASn,CASn,WEn}:
  - NOP = 0,1,1,F.
  - ACT = 0,0,1,F; A = row.
  - READ = 0,1,0,F; A = {1'b0, col}.
  - WRITE = 0,1,0,~strb; A = {1'b0, col}; D = wdata.
  - PRE = 0,0,1,0.
- Every command is a single-cycle pulse; NOP on all other cycles.
- Reset values (while rst low): CSn=1, RASn=1, CASn=1, WEn=F, A=0, D=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, row_open=0, state=IDLE.
- States:
  - IDLE: req_ready=1. On valid & ready, latch we/strb/addr/wdata.
    - Row open and row matches -> COL.
    - Row open and row differs -> PRE.
    - No row open -> ACT.
  - PRE: issue PRE, clear row_open, wait T_RP cycles -> ACT.
  - ACT: issue ACT, latch open row, set row_open, wait T_RCD cycles -> COL.
  - COL: issue READ or WRITE.
    - Read -> RWAIT.
    - Write -> WWAIT.
  - RWAIT: on the first cycle DRAM_valid=1, capture Q into rsp_rdata -> DONE. If T_CL cycles pass without VALID: rsp_err=1, rsp_rdata=0 -> DONE.
  - WWAIT: wait T_WR cycles -> DONE.
  - DONE: rsp_valid=1 for exactly one cycle -> IDLE.
- req_ready is high only in IDLE; it deasserts the cycle after acceptance. No request is accepted while a command is in flight.
- Wait counters load the parameter value minus 1 and count down to 0. A parameter value of 1 means the next state follows immediately.
- A write with strb=0 still issues WRITE with WEn=F (no bytes change) and completes normally.
- Latency, row hit, defaults:
  - Read: accept -> COL 1 cycle, VALID wait, then DONE.
  - Write: 1 + T_WR + 1 cycles from accept to rsp_valid.
- DRAM_valid outside RWAIT is ignored.
- rst asserted mid-operation returns all outputs to reset values immediately; row_open clears, so the first access after reset always issues ACT.
- A new req_valid arriving during DONE is not accepted until the following IDLE cycle.

Optional Feature:
- Macro DRAM_CLOSE_PAGE_EN.
- Defined: closed-page policy. Every access ends with PRE (after the VALID capture or after T_WR), then T_RP cycles, then DONE. row_open never persists, so every access issues ACT.
- Undefined: open-page policy as described above; the row stays open until a row miss.

Test Plan:
- Reset, then read addr 0x0010_0004 (row 0x100, col 1), DRAM returns VALID with Q=0xDEADBEEF -> sequence ACT(A=0x100), READ(A=0x001); rsp_valid pulse with rdata=0xDEADBEEF, err=0.
- Write addr 0x0010_0008, strb=4'b0101, wdata=0x11223344, right after that read -> no PRE/ACT (row hit); WRITE with WEn=4'b1010, A=0x002, D=0x11223344; rsp_valid exactly 1+T_WR+1 = 7 cycles after accept.
- Read 0x0020_0000 while row 0x100 is open -> PRE, 5 cycles, ACT(A=0x200), 5 cycles, READ(A=0).
- Read with DRAM_valid held low -> after T_CL=5 cycles, rsp_valid=1, rsp_err=1, rdata=0.
- Assert rst during RWAIT -> outputs return to reset values in the same cycle; the next read of the same row issues ACT first.
- With DRAM_CLOSE_PAGE_EN, two consecutive reads to row 0x100 -> each read shows ACT, READ, PRE; req_ready stays low until T_RP elapses after each PRE.

Source files
------------

// File: rtl/dram_ctrl.sv
// dram_ctrl: single-request DRAM command sequencer (ACT/READ/WRITE/PRE) with parameterised timing
// Ports: clk, rst (async active-low); req_* request in, rsp_* response out; DRAM_* device pins.
// Define DRAM_CLOSE_PAGE_EN for a closed-page policy (PRE after every access); default is open-page.
module dram_ctrl #(
  parameter int T_RCD = 5,
  parameter int T_RP  = 5,
  parameter int T_CL  = 5,
  parameter int T_WR  = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [3:0]  req_strb,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        DRAM_CSn,
  output logic        DRAM_RASn,
  output logic        DRAM_CASn,
  output logic [3:0]  DRAM_WEn,
  output logic [10:0] DRAM_A,
  output logic [31:0] DRAM_D,
  input  logic [31:0] DRAM_Q,
  input  logic        DRAM_valid
);
  typedef enum logic [2:0] {IDLE, PRE, ACT, COL, RWAIT, WWAIT, DONE} state_t;
`ifdef DRAM_CLOSE_PAGE_EN
  localparam bit CLOSE = 1'b1;
`else
  localparam bit CLOSE = 1'b0;
`endif
  localparam logic [7:0] L_RCD = 8'(T_RCD - 1);
  localparam logic [7:0] L_RP  = 8'(T_RP - 1);
  localparam logic [7:0] L_CL  = 8'(T_CL - 1);
  localparam logic [7:0] L_WR  = 8'(T_WR - 1);
  // After the data phase: closed-page goes through PRE before DONE
  localparam state_t FIN = CLOSE ? PRE : DONE;
  state_t      state, state_d;
  logic [7:0]  cnt, cnt_d;
  logic        we_q, row_open;
  logic [3:0]  strb_q;
  logic [20:0] addr_q;
  logic [31:0] wdata_q;
  logic [10:0] row_q;
  logic        hit, act_c, pre_c, col_c;
  wire         unused_addr = &{1'b0, req_addr[31:23], req_addr[1:0]};
  assign hit = row_open && req_addr[22:12] == row_q;
  always_comb begin
    state_d = state;
    cnt_d = cnt == 8'd0 ? 8'd0 : cnt - 8'd1;
    case (state)
      IDLE: if (req_valid) begin
        state_d = hit ? COL : row_open ? PRE : ACT;
        cnt_d = row_open && !hit ? L_RP : L_RCD;
      end
      PRE: if (cnt == 8'd0) begin
        state_d = CLOSE ? DONE : ACT;
        cnt_d = L_RCD;
      end
      ACT: if (cnt == 8'd0) state_d = COL;
      COL: begin
        state_d = we_q ? WWAIT : RWAIT;
        cnt_d = we_q ? L_WR : L_CL;
      end
      RWAIT: if (DRAM_valid || cnt == 8'd0) begin
        state_d = FIN;
        cnt_d = L_RP;
      end
      WWAIT: if (cnt == 8'd0) begin
        state_d = FIN;
        cnt_d = L_RP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= 8'd0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q <= 1'b0;
      strb_q <= 4'h0;
      addr_q <= '0;
      wdata_q <= '0;
      row_q <= '0;
      row_open <= 1'b0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        we_q <= req_we;
        strb_q <= req_strb;
        addr_q <= req_addr[22:2];
        wdata_q <= req_wdata;
      end
      if (state == ACT) begin
        row_q <= addr_q[20:10];
        row_open <= 1'b1;
      end
      if (state == PRE) row_open <= 1'b0;
      if (state == RWAIT && (DRAM_valid || cnt == 8'd0)) begin
        rsp_rdata <= DRAM_valid ? DRAM_Q : 32'd0;
        rsp_err <= !DRAM_valid;
      end
      if (state == WWAIT) rsp_err <= 1'b0;
    end
  end
  // Commands pulse only on the first cycle of their state (counter still at its load value)
  assign act_c = state == ACT && cnt == L_RCD;
  assign pre_c = state == PRE && cnt == L_RP;
  assign col_c = state == COL;
  assign req_ready = rst && state == IDLE;
  assign rsp_valid = state == DONE;
  assign DRAM_CSn = !rst;
  assign DRAM_RASn = !(act_c || pre_c);
  assign DRAM_CASn = !col_c;
  assign DRAM_WEn = pre_c ? 4'h0 : col_c && we_q ? ~strb_q : 4'hF;
  assign DRAM_A = act_c ? addr_q[20:10] : col_c ? {1'b0, addr_q[9:0]} : 11'd0;
  assign DRAM_D = col_c && we_q ? wdata_q : 32'd0;
endmodule

// File: tb/tb_dram_ctrl.sv
// tb_dram_ctrl: directed self-checking bench for dram_ctrl with hand-computed expectations
module tb_dram_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, DRAM_valid = 1'b0;
  logic [3:0]  req_strb = 4'h0;
  logic [31:0] req_addr = '0, req_wdata = '0, DRAM_Q = '0;
  logic        req_ready, rsp_valid, rsp_err, DRAM_CSn, DRAM_RASn, DRAM_CASn;
  logic [31:0] rsp_rdata, DRAM_D;
  logic [3:0]  DRAM_WEn;
  logic [10:0] DRAM_A;
  logic [17:0] cmd;
  int          n_vec = 0, n_err = 0;
  dram_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_strb(req_strb), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .DRAM_CSn(DRAM_CSn), .DRAM_RASn(DRAM_RASn),
    .DRAM_CASn(DRAM_CASn), .DRAM_WEn(DRAM_WEn), .DRAM_A(DRAM_A), .DRAM_D(DRAM_D),
    .DRAM_Q(DRAM_Q), .DRAM_valid(DRAM_valid)
  );
  always #5 clk = ~clk;
  assign cmd = {DRAM_CSn, DRAM_RASn, DRAM_CASn, DRAM_WEn, DRAM_A};
  function automatic logic [17:0] c(input logic ras, input logic cas, input logic [3:0] wen, input logic [10:0] a);
    return {1'b0, ras, cas, wen, a};
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic we, input logic [3:0] strb, input logic [31:0] addr, input logic [31:0] wd);
    req_valid = 1'b1;
    req_we = we;
    req_strb = strb;
    req_addr = addr;
    req_wdata = wd;
    step(1);
    req_valid = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    step(1);
    chk("rst_cmd", 32'(cmd), 32'({1'b1, 1'b1, 1'b1, 4'hF, 11'h0}));
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp", {rsp_valid, rsp_err, 30'd0}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_d", DRAM_D, 32'd0);
    rst = 1'b1;
    step(1);
    chk("idle_ready", 32'(req_ready), 32'd1);
    chk("idle_nop", 32'(cmd), 32'(c(1, 1, 4'hF, 11'h0)));
`ifndef DRAM_CLOSE_PAGE_EN
    issue(1'b0, 4'h0, 32'h0010_0004, 32'h0);
    chk("rd1_act", 32'(cmd), 32'(c(0, 1, 4'hF, 11'h100)));
    chk("rd1_busy", 32'(req_ready), 32'd0);
    step(4);
    chk("rd1_act_wait", 32'(cmd), 32'(c(1, 1, 4'hF, 11'h0)));
    step(1);
    chk("rd1_read", 32'(cmd), 32'(c(1, 0, 4'hF, 11'h001)));
    step(1);
    chk("rd1_wait", 32'(rsp_valid), 32'd0);
    DRAM_valid = 1'b1;
    DRAM_Q = 32'hDEAD_BEEF;
    step(1);
    DRAM_valid = 1'b0;
    chk("rd1_rsp", {rsp_valid, rsp_err, 30'd0}, {1'b1, 1'b0, 30'd0});
    chk("rd1_rdata", rsp_rdata, 32'hDEAD_BEEF);
    step(1);
    chk("rd1_pulse", 32'(rsp_valid), 32'd0);
    issue(1'b1, 4'b0101, 32'h0010_0008, 32'h1122_3344);
    chk("wr_hit_cmd", 32'(cmd), 32'(c(1, 0, 4'b1010, 11'h002)));
    chk("wr_d", DRAM_D, 32'h1122_3344);
    step(5);
    chk("wr_wait", 32'(rsp_valid), 32'd0);
    step(1);
    chk("wr_rsp7", {rsp_valid, rsp_err, 30'd0}, {1'b1, 1'b0, 30'd0});
    step(1);
    issue(1'b0, 4'h0, 32'h0020_0000, 32'h0);
    chk("miss_pre", 32'(cmd), 32'(c(0, 1, 4'h0, 11'h0)));
    step(1);
    chk("miss_nop", 32'(cmd), 32'(c(1, 1, 4'hF, 11'h0)));
    step(4);
    chk("miss_act", 32'(cmd), 32'(c(0, 1, 4'hF, 11'h200)));
    step(5);
    chk("miss_read", 32'(cmd), 32'(c(1, 0, 4'hF, 11'h000)));
    step(5);
    chk("to_wait", 32'(rsp_valid), 32'd0);
    step(1);
    chk("to_rsp", {rsp_valid, rsp_err, 30'd0}, {1'b1, 1'b1, 30'd0});
    chk("to_rdata", rsp_rdata, 32'd0);
    step(1);
    issue(1'b0, 4'h0, 32'h0020_0010, 32'h0);
    chk("hit2_read", 32'(cmd), 32'(c(1, 0, 4'hF, 11'h004)));
    step(1);
    rst = 1'b0;
    #1;
    chk("mid_rst_cmd", 32'(cmd), 32'({1'b1, 1'b1, 1'b1, 4'hF, 11'h0}));
    chk("mid_rst_rsp", {rsp_valid, rsp_err, req_ready, 29'd0}, 32'd0);
    #2;
    rst = 1'b1;
    step(1);
    issue(1'b0, 4'h0, 32'h0020_0010, 32'h0);
    chk("post_rst_act", 32'(cmd), 32'(c(0, 1, 4'hF, 11'h200)));
    step(5);
    chk("post_rst_read", 32'(cmd), 32'(c(1, 0, 4'hF, 11'h004)));
    step(1);
    DRAM_valid = 1'b1;
    DRAM_Q = 32'hCAFE_F00D;
    step(1);
    DRAM_valid = 1'b0;
    chk("post_rst_rdata", rsp_rdata, 32'hCAFE_F00D);
    step(1);
    issue(1'b1, 4'h0, 32'h0020_0014, 32'h5555_AAAA);
    chk("wr0_cmd", 32'(cmd), 32'(c(1, 0, 4'hF, 11'h005)));
    step(6);
    chk("wr0_rsp", {rsp_valid, rsp_err, 30'd0}, {1'b1, 1'b0, 30'd0});
    step(1);
`else
    for (int i = 0; i < 2; i++) begin
      issue(1'b0, 4'h0, 32'h0010_0004, 32'h0);
      chk("cp_act", 32'(cmd), 32'(c(0, 1, 4'hF, 11'h100)));
      step(5);
      chk("cp_read", 32'(cmd), 32'(c(1, 0, 4'hF, 11'h001)));
      step(1);
      DRAM_valid = 1'b1;
      DRAM_Q = 32'h0BAD_F00D + i;
      step(1);
      DRAM_valid = 1'b0;
      chk("cp_pre", 32'(cmd), 32'(c(0, 1, 4'h0, 11'h0)));
      step(4);
      chk("cp_busy", {req_ready, rsp_valid, 30'd0}, 32'd0);
      step(1);
      chk("cp_rsp", 32'(rsp_valid), 32'd1);
      chk("cp_rdata", rsp_rdata, 32'h0BAD_F00D + i);
      step(1);
      chk("cp_ready", 32'(req_ready), 32'd1);
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
